linescanner_line_scheduler: RTL and testbench
=============================================

// Module: linescanner_line_scheduler
// PURPOSE
//  Sequences linescanner acquisition: enables the capture unit, frames lval-qualified pixels
//  into lines and lines into frames, enforces an inter-line gap and flags length errors.
//  Sits between host control registers and the capture unit.
//  Drives the capture unit's enable and tags each pixel with pixel/line indices for the line buffer.
// PARAMETERS
//  PIXELS_PER_LINE  1024  expected lval-high cycles per line
//  LINES_PER_FRAME  512   lines per frame
//  LINE_GAP_CLOCKS  16    cycles capture_enable held low between lines (>=1)
//  TIMEOUT_CLOCKS   4096  WAIT_LVAL watchdog limit (LINE_TIMEOUT_EN only)
//  PIX_W            11    pixel_index width; must hold PIXELS_PER_LINE
//  LINE_W           10    line_index width; must hold LINES_PER_FRAME-1
// PORTS
//  pixel_clock     in   1       single clock, all logic on rising edge
//  n_reset         in   1       asynchronous, active-low reset
//  start           in   1       1-cycle pulse: begin frame
//  stop            in   1       1-cycle pulse: stop acquisition
//  continuous      in   1       1 = auto-restart next frame after frame_done
//  lval            in   1       line valid from sensor
//  capture_enable  out  1       to capture unit enable
//  pixel_strobe    out  1       pixel valid (registered)
//  pixel_index     out  PIX_W   index of strobed pixel, 0-based
//  line_index      out  LINE_W  current line in frame, 0-based
//  frame_start     out  1       pulse, first cycle of new frame
//  line_done       out  1       pulse, line closed
//  frame_done      out  1       pulse, last line of full frame closed
//  line_error      out  1       pulse with line_done when count != PIXELS_PER_LINE
//  len_err_sticky  out  1       set by line_error, cleared only by start accepted in IDLE
//  timeout         out  1       pulse, watchdog expired (0 without LINE_TIMEOUT_EN)
//  busy            out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, stop_pending 0, lval_d 0.
//  lval registered to lval_d; rise = lval & !lval_d, fall = !lval & lval_d.
//  IDLE: capture_enable=0. start & !stop -> WAIT_LVAL next cycle; frame_start=1 that cycle,
//   line_index=0, len_err_sticky cleared. start&stop same cycle: ignored. start when busy: ignored.
//  WAIT_LVAL: capture_enable=1. rise -> CAPTURE; that cycle pixel_strobe=1, pixel_index=0, cnt=1.
//   stop (or stop_pending) -> IDLE immediately, no line_done.
//  CAPTURE: each lval=1 cycle: pixel_strobe=1, pixel_index=cnt, cnt++ saturating at 2^PIX_W-1.
//   stop sets stop_pending; line always completes. fall -> line_done=1;
//   line_error=1 if cnt!=PIXELS_PER_LINE. Then:
//   line_index<LINES_PER_FRAME-1: line_index++, -> GAP.
//   last line: frame_done=1; continuous & !stop_pending -> GAP, line_index=0, frame_start=1
//   on GAP exit; else -> IDLE.
//  GAP: capture_enable=0 for exactly LINE_GAP_CLOCKS cycles, then WAIT_LVAL;
//   stop/stop_pending -> IDLE at GAP end. lval during GAP ignored, not counted.
//  stop_pending cleared on entry to IDLE. pixel_strobe/index registered: 1-cycle latency after lval.
//  Pulses last exactly 1 cycle. Async reset mid-line: immediate return to reset values.
// CONFIGURATION
//  LINE_TIMEOUT_EN defined: WAIT_LVAL counts cycles; at TIMEOUT_CLOCKS without rise ->
//   timeout=1 for 1 cycle, capture_enable=0, -> IDLE (counter cleared on every WAIT_LVAL entry).
//  LINE_TIMEOUT_EN undefined: no watchdog logic; timeout tied 0; WAIT_LVAL waits indefinitely.
// TESTING
//  PIXELS_PER_LINE=8, LINES_PER_FRAME=2, LINE_GAP_CLOCKS=4, continuous=0 for all unless noted.
//  start, two lines of 8 lval cycles -> 16 strobes idx 0..7 twice, 2 line_done, 1 frame_done, IDLE.
//  line of 7 lval cycles -> line_error + line_done same cycle, len_err_sticky=1 until next start.
//  continuous=1, 2 frames -> frame_start twice, gap of 4 enable-low cycles between all lines.
//  stop mid-CAPTURE line 0 -> line completes (line_done), no frame_done, IDLE, busy=0.
//  start&stop same cycle in IDLE -> no frame_start, busy stays 0; n_reset low mid-line -> all 0.
//  LINE_TIMEOUT_EN, TIMEOUT_CLOCKS=20, no lval -> timeout pulse 20 cycles after WAIT_LVAL, IDLE.

Source files
------------

// File: rtl/linescanner_line_scheduler.sv
// Linescanner line scheduler: gates the capture unit, frames lval-qualified pixels into
// lines and lines into frames, enforces an inter-line gap and flags line-length errors.
// Optional watchdog on the wait-for-line state is compiled in with `define LINE_TIMEOUT_EN.
module linescanner_line_scheduler #(
   parameter int unsigned PIXELS_PER_LINE = 1024,
   parameter int unsigned LINES_PER_FRAME = 512,
   parameter int unsigned LINE_GAP_CLOCKS = 16,
   parameter int unsigned TIMEOUT_CLOCKS  = 4096,
   parameter int unsigned PIX_W           = 11,
   parameter int unsigned LINE_W          = 10
) (
   input  logic              pixel_clock,
   input  logic              n_reset,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic              lval,
   output logic              capture_enable,
   output logic              pixel_strobe,
   output logic [PIX_W-1:0]  pixel_index,
   output logic [LINE_W-1:0] line_index,
   output logic              frame_start,
   output logic              line_done,
   output logic              frame_done,
   output logic              line_error,
   output logic              len_err_sticky,
   output logic              timeout,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StWaitLval, StCapture, StGap} state_e;

   localparam int unsigned       GAP_W      = $clog2(LINE_GAP_CLOCKS + 1);
   localparam logic [PIX_W-1:0]  PIX_MAX    = '1;
   localparam logic [PIX_W-1:0]  PIX_EXPECT = PIX_W'(PIXELS_PER_LINE);
   localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(LINES_PER_FRAME - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(LINE_GAP_CLOCKS - 1);

   // Reject configurations the counters cannot represent
   if (LINE_GAP_CLOCKS < 1 || TIMEOUT_CLOCKS < 1 || LINES_PER_FRAME < 1 ||
       PIXELS_PER_LINE > (2 ** PIX_W) - 1 || LINES_PER_FRAME - 1 > (2 ** LINE_W) - 1)
   begin : g_bad_params
      $error("linescanner_line_scheduler: inconsistent parameters");
   end

   state_e             state_q;
   logic               lval_q;
   logic               stop_pending_q;
   logic               wrap_q;         // last line closed in continuous mode: restart at gap end
   logic [PIX_W-1:0]   pixel_count_q;
   logic [GAP_W-1:0]   gap_count_q;
   logic               lval_rise;
   logic               lval_fall;
   logic               stop_req;

`ifdef LINE_TIMEOUT_EN
   localparam int unsigned     WD_W    = $clog2(TIMEOUT_CLOCKS + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLOCKS - 1);
   logic [WD_W-1:0]            watchdog_q;
`else
   assign timeout = 1'b0;
`endif

   assign lval_rise = lval & ~lval_q;
   assign lval_fall = ~lval & lval_q;
   assign stop_req  = stop | stop_pending_q;
   assign busy      = (state_q != StIdle);

   // Acquisition sequencer with all outputs registered
   always_ff @(posedge pixel_clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q        <= StIdle;
         lval_q         <= 1'b0;
         stop_pending_q <= 1'b0;
         wrap_q         <= 1'b0;
         pixel_count_q  <= '0;
         gap_count_q    <= '0;
         capture_enable <= 1'b0;
         pixel_strobe   <= 1'b0;
         pixel_index    <= '0;
         line_index     <= '0;
         frame_start    <= 1'b0;
         line_done      <= 1'b0;
         frame_done     <= 1'b0;
         line_error     <= 1'b0;
         len_err_sticky <= 1'b0;
`ifdef LINE_TIMEOUT_EN
         watchdog_q     <= '0;
         timeout        <= 1'b0;
`endif
      end else begin
         lval_q       <= lval;
         pixel_strobe <= 1'b0;
         frame_start  <= 1'b0;
         line_done    <= 1'b0;
         frame_done   <= 1'b0;
         line_error   <= 1'b0;
`ifdef LINE_TIMEOUT_EN
         timeout      <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (start && !stop) begin
                  state_q        <= StWaitLval;
                  capture_enable <= 1'b1;
                  frame_start    <= 1'b1;
                  line_index     <= '0;
                  len_err_sticky <= 1'b0;
`ifdef LINE_TIMEOUT_EN
                  watchdog_q     <= '0;
`endif
               end
            end
            StWaitLval: begin
               if (stop_req) begin
                  state_q        <= StIdle;
                  capture_enable <= 1'b0;
                  stop_pending_q <= 1'b0;
               end else if (lval_rise) begin
                  state_q       <= StCapture;
                  pixel_strobe  <= 1'b1;
                  pixel_index   <= '0;
                  pixel_count_q <= PIX_W'(1);
               end
`ifdef LINE_TIMEOUT_EN
               else if (watchdog_q == WD_LAST) begin
                  state_q        <= StIdle;
                  capture_enable <= 1'b0;
                  timeout        <= 1'b1;
               end else begin
                  watchdog_q <= watchdog_q + WD_W'(1);
               end
`endif
            end
            StCapture: begin
               // A stop never truncates a line; it takes effect at the next boundary
               if (stop) stop_pending_q <= 1'b1;
               if (lval) begin
                  pixel_strobe <= 1'b1;
                  pixel_index  <= pixel_count_q;
                  if (pixel_count_q != PIX_MAX) pixel_count_q <= pixel_count_q + PIX_W'(1);
               end else if (lval_fall) begin
                  line_done      <= 1'b1;
                  capture_enable <= 1'b0;
                  gap_count_q    <= '0;
                  if (pixel_count_q != PIX_EXPECT) begin
                     line_error     <= 1'b1;
                     len_err_sticky <= 1'b1;
                  end
                  if (line_index < LAST_LINE) begin
                     line_index <= line_index + LINE_W'(1);
                     state_q    <= StGap;
                  end else begin
                     frame_done <= 1'b1;
                     if (continuous && !stop_req) begin
                        state_q <= StGap;
                        wrap_q  <= 1'b1;
                     end else begin
                        state_q        <= StIdle;
                        stop_pending_q <= 1'b0;
                     end
                  end
               end
            end
            StGap: begin
               if (stop) stop_pending_q <= 1'b1;
               if (gap_count_q == GAP_LAST) begin
                  wrap_q <= 1'b0;
                  if (stop_req) begin
                     state_q        <= StIdle;
                     stop_pending_q <= 1'b0;
                  end else begin
                     state_q        <= StWaitLval;
                     capture_enable <= 1'b1;
`ifdef LINE_TIMEOUT_EN
                     watchdog_q     <= '0;
`endif
                     if (wrap_q) begin
                        line_index  <= '0;
                        frame_start <= 1'b1;
                     end
                  end
               end else begin
                  gap_count_q <= gap_count_q + GAP_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_linescanner_line_scheduler.sv
// Self-checking bench for linescanner_line_scheduler (8 pixels/line, 2 lines/frame, gap 4).
module tb_linescanner_line_scheduler;

   logic       pixel_clock = 1'b0;
   logic       n_reset     = 1'b0;
   logic       start       = 1'b0;
   logic       stop        = 1'b0;
   logic       continuous  = 1'b0;
   logic       lval        = 1'b0;
   logic       capture_enable, pixel_strobe, frame_start, line_done, frame_done;
   logic       line_error, len_err_sticky, timeout, busy;
   logic [3:0] pixel_index;
   logic [0:0] line_index;
   logic [13:0] obs;

   int n_vec = 0;
   int n_bad = 0;
   int n_fs, n_ld, n_fd, n_le, n_ps;

   typedef struct {
      logic        start;
      logic        stop;
      logic        lval;
      logic [13:0] exp;
   } vec_t;
   vec_t vecs[$];

   linescanner_line_scheduler #(
      .PIXELS_PER_LINE(8),
      .LINES_PER_FRAME(2),
      .LINE_GAP_CLOCKS(4),
      .TIMEOUT_CLOCKS (20),
      .PIX_W          (4),
      .LINE_W         (1)
   ) dut (
      .pixel_clock   (pixel_clock),
      .n_reset       (n_reset),
      .start         (start),
      .stop          (stop),
      .continuous    (continuous),
      .lval          (lval),
      .capture_enable(capture_enable),
      .pixel_strobe  (pixel_strobe),
      .pixel_index   (pixel_index),
      .line_index    (line_index),
      .frame_start   (frame_start),
      .line_done     (line_done),
      .frame_done    (frame_done),
      .line_error    (line_error),
      .len_err_sticky(len_err_sticky),
      .timeout       (timeout),
      .busy          (busy)
   );

   always #5 pixel_clock = ~pixel_clock;

   assign obs = {capture_enable, pixel_strobe, pixel_index, line_index, frame_start, line_done,
                 frame_done, line_error, len_err_sticky, busy, timeout};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   task automatic step();
      @(posedge pixel_clock);
      #1;
      if (frame_start)  n_fs++;
      if (line_done)    n_ld++;
      if (frame_done)   n_fd++;
      if (line_error)   n_le++;
      if (pixel_strobe) n_ps++;
   endtask

   task automatic clear_counts();
      n_fs = 0; n_ld = 0; n_fd = 0; n_le = 0; n_ps = 0;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_obs(input string name, input logic [13:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (ce ps idx[4] li fs ld fd le st busy to)",
                  name, obs, exp);
      end
   endtask

   task automatic add(input logic s, t, l, ce, ps, input logic [3:0] pi,
                      input logic li, fs, ld, fd, le, st, by);
      vec_t v;
      v.start = s; v.stop = t; v.lval = l;
      v.exp   = {ce, ps, pi, li, fs, ld, fd, le, st, by, 1'b0};
      vecs.push_back(v);
   endtask

   initial begin
      int guard;
      int low;
      int cycles;

      // s t l  ce ps idx li fs ld fd le st by
      add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);  // start accepted
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // waiting for lval
      for (int i = 0; i < 8; i++) add(0, 0, 1, 1, 1, 4'(i), 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 1);  // line 0 closes, good length
      add(0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1);  // lval in gap ignored
      add(0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 1);  // gap over after 4 low cycles
      for (int i = 0; i < 7; i++) add(0, 0, 1, 1, 1, 4'(i), 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 6, 1, 0, 1, 1, 1, 1, 0);  // short line: error + frame end
      add(0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0);
      add(1, 1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0);  // start&stop ignored
      add(0, 1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0);  // stop in idle ignored
      add(1, 0, 0, 1, 0, 6, 0, 1, 0, 0, 0, 0, 1);  // start clears sticky
      add(0, 1, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0);  // stop in wait -> idle

      #2;
      check_obs("reset state", 14'd0);
      #20 n_reset = 1'b1;
      step();
      check_obs("idle after reset", 14'd0);

      foreach (vecs[k]) begin
         start = vecs[k].start;
         stop  = vecs[k].stop;
         lval  = vecs[k].lval;
         step();
         check_obs($sformatf("vector %0d", k), vecs[k].exp);
      end
      start = 1'b0; stop = 1'b0; lval = 1'b0;

      // Continuous mode over two frames
      clear_counts();
      continuous = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int ln = 0; ln < 4; ln++) begin
         if (ln == 3) continuous = 1'b0;
         guard = 0;
         while (!capture_enable && guard < 20) begin
            step();
            guard++;
         end
         check("cont enable", 32'(capture_enable), 1);
         check("cont line_index", 32'(line_index), ln % 2);
         lval = 1'b1;
         for (int i = 0; i < 8; i++) begin
            step();
            check("cont strobe/index", 32'({pixel_strobe, pixel_index}), 16 + i);
         end
         lval = 1'b0;
         step();
         check("cont line_done", 32'(line_done), 1);
         if (ln != 3) begin
            low = 0;
            guard = 0;
            while (!capture_enable && guard < 20) begin
               low++;
               step();
               guard++;
            end
            check("cont gap length", low, 4);
         end
      end
      check("cont frame_start count", n_fs, 2);
      check("cont frame_done count", n_fd, 2);
      check("cont line_done count", n_ld, 4);
      check("cont line_error count", n_le, 0);
      check("cont strobe count", n_ps, 32);
      check("cont ends idle", 32'(busy), 0);

      // Stop mid-line: line completes, no frame_done
      clear_counts();
      start = 1'b1;
      step();
      start = 1'b0;
      lval = 1'b1;
      repeat (3) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      repeat (4) step();
      lval = 1'b0;
      step();
      check("stop line_done", 32'(line_done), 1);
      check("stop no frame_done", 32'(frame_done), 0);
      cycles = 0;
      while (busy && cycles < 20) begin
         step();
         cycles++;
      end
      check("stop cycles to idle", cycles, 4);
      check("stop strobe count", n_ps, 8);
      check("stop frame_done count", n_fd, 0);
      check("stop enable low", 32'(capture_enable), 0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("stop_pending cleared", 32'(busy), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop from wait", 32'(busy), 0);

      // Asynchronous reset mid-line
      start = 1'b1;
      step();
      start = 1'b0;
      lval = 1'b1;
      repeat (3) step();
      #2 n_reset = 1'b0;
      #1;
      check_obs("async reset mid-line", 14'd0);
      lval = 1'b0;
      #3 n_reset = 1'b1;
      step();
      check_obs("idle after async reset", 14'd0);

`ifdef LINE_TIMEOUT_EN
      start = 1'b1;
      step();
      start = 1'b0;
      cycles = 0;
      while (!timeout && cycles < 40) begin
         step();
         cycles++;
      end
      check("timeout latency", cycles, 20);
      check("timeout enable low", 32'(capture_enable), 0);
      check("timeout idle", 32'(busy), 0);
      step();
      check("timeout one cycle", 32'(timeout), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
